shift_compute_seq: RTL and testbench

Sequencer for the serial shift/compute tile datapath (16-bit serial-in shift register, registered 8-bit ADD and AND units, 4-way result select). Accepts one parallel request `{a, b, op}` over a valid/ready handshake and shifts both operands in serially. It then pulses the capture enable, steers the result select, samples the datapath output, and returns one 8-bit result over a second valid/ready handshake. It sits between the tile's host-side control logic and the datapath pins.

---
 rtl/shift_compute_seq_if.sv | 44 ++++
 rtl/shift_compute_seq.sv | 158 +++++++++++++++
 tb/tb_shift_compute_seq.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_compute_seq_if.sv
// Request/result handshake bundle for shift_compute_seq.
//
// Signals:
//   req_valid / req_ready : request handshake, transfer when both high at a clock edge
//   req_a, req_b          : 8-bit operands
//   req_op                : 00 ADD, 01 AND, 10 PASS_A, 11 PASS_B
//   res_valid / res_ready : result handshake, transfer when both high at a clock edge
//   res_data              : 8-bit result, stable while res_valid is high
//
// Modports:
//   master : host side; issues requests and consumes results
//   slave  : sequencer side
interface shift_compute_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] req_op;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output req_op,
    output res_ready,
    input  req_ready,
    input  res_valid,
    input  res_data
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_op,
    input  res_ready,
    output req_ready,
    output res_valid,
    output res_data
  );
endinterface

// File: rtl/shift_compute_seq.sv
// Sequencer for the serial shift/compute tile datapath.
//
// Accepts one {a, b, op} request, shifts {a, b} MSB-first into the datapath's 16-bit serial
// shift chain, pulses the ADD or AND capture enable when needed, steers the result select,
// samples the datapath output and returns the 8-bit result over a valid/ready handshake.
//
// Ports:
//   clk        : single clock, shared with the datapath
//   rst        : synchronous active-high reset
//   bus        : request/result handshake (slave modport)
//   dp_sd      : datapath serial data in (bit 0 of the shift chain)
//   dp_sel     : datapath result select (00 shift[7:0], 01 shift[15:8], 10 add, 11 and)
//   dp_en_add  : datapath ADD register capture enable
//   dp_en_and  : datapath AND register capture enable
//   dp_rst_n   : datapath rst_n; low only in the cycle the result is sampled
//   dp_res     : datapath result output
module shift_compute_seq (
  input  logic                      clk,
  input  logic                      rst,
  shift_compute_seq_if.slave        bus,
  output logic                      dp_sd,
  output logic [1:0]                dp_sel,
  output logic                      dp_en_add,
  output logic                      dp_en_and,
  output logic                      dp_rst_n,
  input  logic [7:0]                dp_res
);

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StExec,
    StSample,
    StDone
  } state_e;

  localparam logic [1:0] OpAdd   = 2'b00;
  localparam logic [1:0] OpAnd   = 2'b01;
  localparam logic [1:0] OpPassA = 2'b10;
  localparam logic [1:0] OpPassB = 2'b11;

  localparam logic [1:0] SelLo  = 2'b00;  // shift[7:0], operand B
  localparam logic [1:0] SelHi  = 2'b01;  // shift[15:8], operand A
  localparam logic [1:0] SelAdd = 2'b10;
  localparam logic [1:0] SelAnd = 2'b11;

  state_e      state_q, state_d;
  logic [15:0] tx_q, tx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  res_q, res_d;

  logic        req_ready_raw;
  logic        res_valid_raw;

  always_comb begin
    state_d       = state_q;
    tx_d          = tx_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    res_d         = res_q;
    req_ready_raw = 1'b0;
    res_valid_raw = 1'b0;
    dp_sd         = 1'b0;
    dp_sel        = SelLo;
    dp_en_add     = 1'b0;
    dp_en_and     = 1'b0;
    dp_rst_n      = 1'b1;

    unique case (state_q)
      StIdle: begin
        req_ready_raw = 1'b1;
        if (bus.req_valid) begin
          tx_d    = {bus.req_a, bus.req_b};
          op_d    = bus.req_op;
          cnt_d   = 4'd0;
          state_d = StShift;
        end
      end

      StShift: begin
        // MSB of A leaves first so the chain ends up holding {a, b}.
        dp_sd = tx_q[15];
        tx_d  = {tx_q[14:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = StExec;
        end
      end

      StExec: begin
        // The chain holds {a, b} this cycle: capture for ADD/AND, or read it out directly.
        unique case (op_q)
          OpAdd: begin
            dp_en_add = 1'b1;
            state_d   = StSample;
          end
          OpAnd: begin
            dp_en_and = 1'b1;
            state_d   = StSample;
          end
          OpPassA: begin
            dp_sel   = SelHi;
            dp_rst_n = 1'b0;
            res_d    = dp_res;
            state_d  = StDone;
          end
          OpPassB: begin
            dp_sel   = SelLo;
            dp_rst_n = 1'b0;
            res_d    = dp_res;
            state_d  = StDone;
          end
        endcase
      end

      StSample: begin
        dp_sel   = (op_q == OpAnd) ? SelAnd : SelAdd;
        dp_rst_n = 1'b0;
        res_d    = dp_res;
        state_d  = StDone;
      end

      StDone: begin
        res_valid_raw = 1'b1;
        if (bus.res_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tx_q    <= 16'h0000;
      cnt_q   <= 4'd0;
      op_q    <= OpAdd;
      res_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  // Do not advertise readiness while reset is held, even though the state is already IDLE.
  assign bus.req_ready = req_ready_raw & ~rst;
  assign bus.res_valid = res_valid_raw;
  assign bus.res_data  = res_q;

endmodule

// File: tb/tb_shift_compute_seq.sv
// Self-checking bench for shift_compute_seq with a behavioural datapath model and a
// scoreboard queue of expected results checked by an independent monitor.
module tb_shift_compute_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_compute_seq_if bus();

  logic       dp_sd;
  logic [1:0] dp_sel;
  logic       dp_en_add;
  logic       dp_en_and;
  logic       dp_rst_n;
  logic [7:0] dp_res;

  shift_compute_seq dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dp_sd     (dp_sd),
    .dp_sel    (dp_sel),
    .dp_en_add (dp_en_add),
    .dp_en_and (dp_en_and),
    .dp_rst_n  (dp_rst_n),
    .dp_res    (dp_res)
  );

  // Behavioural datapath: serial shift chain, registered ADD/AND, output visible while rst_n low.
  logic [15:0] m_sh  = 16'h0000;
  logic [7:0]  m_add = 8'h00;
  logic [7:0]  m_and = 8'h00;

  always @(posedge clk) begin
    if (!dp_rst_n) begin
      m_sh  <= 16'h0000;
      m_add <= 8'h00;
      m_and <= 8'h00;
    end else begin
      m_sh <= {m_sh[14:0], dp_sd};
      if (dp_en_add) m_add <= m_sh[15:8] + m_sh[7:0];
      if (dp_en_and) m_and <= m_sh[15:8] & m_sh[7:0];
    end
  end

  always_comb begin
    dp_res = 8'h00;
    if (!dp_rst_n) begin
      case (dp_sel)
        2'b00:   dp_res = m_sh[7:0];
        2'b01:   dp_res = m_sh[15:8];
        2'b10:   dp_res = m_add;
        default: dp_res = m_and;
      endcase
    end
  end

  // Result-ready drive: directed value or random, selected by the running phase.
  logic dir_ready = 1'b1;
  logic rnd_ready = 1'b1;
  logic rnd_on    = 1'b0;
  assign bus.res_ready = rnd_on ? rnd_ready : dir_ready;

  always @(posedge clk) begin
    #1 rnd_ready = 1'($urandom_range(0, 1));
  end

  int checks = 0;
  int errors = 0;
  int n_push = 0;
  int n_pop  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_res(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] op);
    logic [7:0] s;
    s = a + b;
    case (op)
      2'b00:   return s;
      2'b01:   return a & b;
      2'b10:   return a;
      default: return b;
    endcase
  endfunction

  // Monitor: every completed result transfer pops one expectation.
  always @(negedge clk) begin
    if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result got %0h expected none", bus.res_data);
      end else begin
        n_pop++;
        check("result", {24'h0, bus.res_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // Issue one request and wait (bounded) for acceptance; returns just after the accept edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    bit got;
    got = 1'b0;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    bus.req_valid = 1'b1;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got no req_ready expected acceptance");
      bus.req_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(ref_res(a, b, op));
      n_push++;
      #1 bus.req_valid = 1'b0;
    end
  endtask

  // Directed request with timing, enable-pulse and serial-bit checks.
  task automatic run_dir(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input int exp_lat);
    int         lat;
    int         n_add;
    int         n_and;
    int         pos;
    logic [15:0] sd;
    lat   = -1;
    n_add = 0;
    n_and = 0;
    pos   = -1;
    sd    = 16'h0000;
    dir_ready = 1'b1;
    send(a, b, op);
    for (int n = 0; n < 40 && lat < 0; n++) begin
      @(negedge clk);
      if (n < 16) sd = {sd[14:0], dp_sd};
      if (dp_en_add === 1'b1) begin n_add++; pos = n; end
      if (dp_en_and === 1'b1) begin n_and++; pos = n; end
      if (bus.res_valid === 1'b1) lat = n;
    end
    check("latency", lat, exp_lat);
    check("sd_seq", {16'h0, sd}, {16'h0, a, b});
    check("en_add_pulses", n_add, (op == 2'b00) ? 1 : 0);
    check("en_and_pulses", n_and, (op == 2'b01) ? 1 : 0);
    check("en_pos", pos, (op[1] == 1'b0) ? 16 : -1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a     = 8'h00;
    bus.req_b     = 8'h00;
    bus.req_op    = 2'b00;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 8'h00);
    check("rst_dp_idle", {dp_sd, dp_sel, dp_en_add, dp_en_and, dp_rst_n}, 6'b000001);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", bus.req_ready, 1);
    @(posedge clk);
    #1;

    // Directed function and timing.
    run_dir(8'h5A, 8'h33, 2'b00, 18);
    run_dir(8'hF0, 8'h3C, 2'b01, 18);
    run_dir(8'hFF, 8'h02, 2'b00, 18);
    run_dir(8'hA5, 8'h00, 2'b10, 17);
    run_dir(8'h3C, 8'hC3, 2'b11, 17);

    // Backpressure in DONE with a competing request held on the bus.
    dir_ready = 1'b0;
    send(8'h12, 8'h34, 2'b00);
    for (int n = 0; n < 40 && bus.res_valid !== 1'b1; n++) @(negedge clk);
    bus.req_a     = 8'h0F;
    bus.req_b     = 8'hFF;
    bus.req_op    = 2'b01;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_res_valid", bus.res_valid, 1);
      check("bp_res_data", bus.res_data, 8'h46);
      check("bp_req_ready", bus.req_ready, 0);
      check("bp_dp_idle", {dp_sd, dp_sel, dp_en_add, dp_en_and, dp_rst_n}, 6'b000001);
    end
    @(posedge clk);
    #1 dir_ready = 1'b1;
    @(negedge clk);
    check("release_req_ready", bus.req_ready, 0);
    @(negedge clk);
    check("after_release_req_ready", bus.req_ready, 1);
    @(posedge clk);
    exp_q.push_back(8'h0F);
    n_push++;
    #1 bus.req_valid = 1'b0;
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(negedge clk);
    check("b2b_drain", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // Reset during SHIFT cycle 8: aborted op must produce no result.
    send(8'h77, 8'h11, 2'b00);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_req_ready", bus.req_ready, 0);
    check("abort_res_valid", bus.res_valid, 0);
    check("abort_res_data", bus.res_data, 8'h00);
    check("abort_dp_idle", {dp_sd, dp_sel, dp_en_add, dp_en_and, dp_rst_n}, 6'b000001);
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_back());
      n_push--;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_release_ready", bus.req_ready, 1);
    begin
      int seen;
      seen = 0;
      for (int n = 0; n < 25; n++) begin
        @(negedge clk);
        if (bus.res_valid === 1'b1) seen++;
      end
      check("abort_no_result", seen, 0);
    end
    @(posedge clk);
    #1;
    run_dir(8'h01, 8'h01, 2'b00, 18);

    // Random traffic with random gaps and result backpressure.
    rnd_on = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
    end
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(negedge clk);
    check("final_drain", exp_q.size(), 0);
    check("result_count", n_pop, n_push);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
